// File: rtl/lut_layer_prog.sv
// Runtime-programmable LUT neuron layer: per-neuron truth tables are loaded over
// a serial config stream, then evaluated in one registered valid/ready stage.
module lut_layer_prog #(
  parameter int IN_BITS     = 8,
  parameter int OUT_BITS    = 1,
  parameter int NUM_NEURONS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_start,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [OUT_BITS-1:0]             cfg_data,
  output logic                            loaded,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_NEURONS*IN_BITS-1:0]  M0,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] M1
);
  localparam int DEPTH = 2 ** IN_BITS;
  localparam int CW    = $clog2(NUM_NEURONS) + IN_BITS;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_NEURONS * DEPTH - 1);

  typedef enum logic [1:0] {UNCFG, LOAD, RUN, DRAIN} state_t;

  state_t                         state_q, state_d;
  logic [CW-1:0]                  cfg_cnt_q, cfg_cnt_d;
  logic                           out_valid_q, out_valid_d;
  logic [NUM_NEURONS*OUT_BITS-1:0] m1_q, m1_d;
  logic [NUM_NEURONS*OUT_BITS-1:0] lut_rd;
  logic                           cfg_we;
  logic                           in_fire;

  assign cfg_ready = (state_q == LOAD);
  assign loaded    = (state_q == RUN);
  assign in_ready  = (state_q == RUN) & ~cfg_start & (~out_valid_q | out_ready);
  assign in_fire   = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign M1        = m1_q;

  // Tables are plain distributed RAM: written only in LOAD, never reset.
  for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_neuron
    logic [OUT_BITS-1:0] tbl_mem [DEPTH];
    logic                sel;

    assign sel = ((cfg_cnt_q >> IN_BITS) == CW'(gi));

    always_ff @(posedge clk) begin
      if (cfg_we && sel) begin
        tbl_mem[cfg_cnt_q[IN_BITS-1:0]] <= cfg_data;
      end
    end

    assign lut_rd[gi*OUT_BITS +: OUT_BITS] = tbl_mem[M0[gi*IN_BITS +: IN_BITS]];
  end

  always_comb begin
    state_d   = state_q;
    cfg_cnt_d = cfg_cnt_q;
    cfg_we    = 1'b0;
    case (state_q)
      UNCFG: begin
        if (cfg_start) begin
          state_d   = LOAD;
          cfg_cnt_d = '0;
        end
      end
      LOAD: begin
        // A restart outranks a beat arriving in the same cycle.
        if (cfg_start) begin
          cfg_cnt_d = '0;
        end else if (cfg_valid) begin
          cfg_we = 1'b1;
          if (cfg_cnt_q == LAST_BEAT) begin
            state_d   = RUN;
            cfg_cnt_d = '0;
          end else begin
            cfg_cnt_d = cfg_cnt_q + CW'(1);
          end
        end
      end
      RUN: begin
        if (cfg_start) begin
          state_d   = out_valid_q ? DRAIN : LOAD;
          cfg_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (~out_valid_q | out_ready) begin
          state_d   = LOAD;
          cfg_cnt_d = '0;
        end
      end
      default: state_d = UNCFG;
    endcase

    out_valid_d = in_fire | (out_valid_q & ~out_ready);
    m1_d        = in_fire ? lut_rd : m1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= UNCFG;
      cfg_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      m1_q        <= '0;
    end else begin
      state_q     <= state_d;
      cfg_cnt_q   <= cfg_cnt_d;
      out_valid_q <= out_valid_d;
      m1_q        <= m1_d;
    end
  end
endmodule
